// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter (mem_arbiter, rr_arb2).
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker: round-robin on contention, or port 0 always wins
// when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = PORT0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (!req[0] && req[1]) gnt = PORT1;
`else
    // On contention the port that was not served last goes first.
    if (req == 2'b11)  gnt = ~last;
    else if (req[1])   gnt = PORT1;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a 256x32 single-port RAM (IDLE -> ACCESS -> DONE).
// Optional fixed priority for port 0 via MEM_ARB_FIXED_PRIO_EN (see rr_arb2).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          nrst,
  // Handshake: req is a level held until the matching ack; we/addr/wdata are
  // latched at grant. ack is a one-cycle pulse in the cycle after the RAM access.
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_nce,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    fsm_state
);

  state_t          state, state_next;
  logic            owner, last;
  logic            gnt, gnt_valid;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_arb2 u_arb (
    .req   ({p1_req, p0_req}),
    .last  (last),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  assign sel_we    = (gnt == PORT1) ? p1_we    : p0_we;
  assign sel_addr  = (gnt == PORT1) ? p1_addr  : p0_addr;
  assign sel_wdata = (gnt == PORT1) ? p1_wdata : p0_wdata;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_valid) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM lines are registered so they are stable for the whole ACCESS cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner     <= PORT0;
      last      <= PORT1;
      ram_nce   <= 1'b1;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt;
            ram_nce   <= 1'b0;
            ram_we    <= sel_we;
            ram_re    <= ~sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          if (ram_re) begin
            if (owner == PORT1) p1_rdata <= ram_rdata;
            else                p0_rdata <= ram_rdata;
          end
          if (owner == PORT1) p1_ack <= 1'b1;
          else                p0_ack <= 1'b1;
          ram_nce <= 1'b1;
          ram_we  <= 1'b0;
          ram_re  <= 1'b0;
          last    <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a RAM model and a
// transaction-level reference model of arbitration order, data and ack timing.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] cyc;
  } exp_t;

  logic        clk, nrst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_nce, ram_we, ram_re;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t        exp_q[$];
  op_t         ops0[$];
  op_t         ops1[$];
  logic [31:0] ref_mem[256];
  logic [31:0] ram[256];
  logic [31:0] m_r0, m_r1;
  logic        m_last;

  mem_arbiter dut (
    .clk(clk), .nrst(nrst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ram_nce(ram_nce), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- RAM model ----------------
  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  assign ram_rdata = (!ram_nce && ram_re) ? ram[ram_addr] : 32'hBAD0F00D;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!ram_nce && ram_we) ram[ram_addr] = ram_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    logic [7:0] a;
    a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
    return mk_op(1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  task automatic drive0(input op_t o);
    p0_we = o.we; p0_addr = o.addr; p0_wdata = o.wdata;
  endtask

  task automatic drive1(input op_t o);
    p1_we = o.we; p1_addr = o.addr; p1_wdata = o.wdata;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_nce"},      32'(ram_nce), 32'd1);
    check({tag, "_we"},       32'(ram_we), 32'd0);
    check({tag, "_re"},       32'(ram_re), 32'd0);
    check({tag, "_addr"},     32'(ram_addr), 32'd0);
    check({tag, "_wdata"},    ram_wdata, 32'd0);
    check({tag, "_p0_ack"},   32'(p0_ack), 32'd0);
    check({tag, "_p1_ack"},   32'(p1_ack), 32'd0);
    check({tag, "_p0_rdata"}, p0_rdata, 32'd0);
    check({tag, "_p1_rdata"}, p1_rdata, 32'd0);
    check({tag, "_state"},    32'(fsm_state), 32'd0);
  endtask

  // ---------------- reference model + driver ----------------
  // Ports hold req until their op list is exhausted; the model replays the
  // service order: single requester wins, contention goes to the port not
  // served last (or port 0 in the fixed-priority build), 3 cycles per access.
  task automatic run_round(input bit early);
    int n, a, b, t, i0, i1, budget;
    logic w;
    op_t o;
    exp_t e;
    @(negedge clk);
    n = cyc; a = 0; b = 0; t = n + 2;
    while (a < ops0.size() || b < ops1.size()) begin
      if (a < ops0.size() && b < ops1.size()) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = ~m_last;
`endif
      end else begin
        w = (a < ops0.size()) ? 1'b0 : 1'b1;
      end
      if (w) begin o = ops1[b]; b++; end
      else   begin o = ops0[a]; a++; end
      if (o.we) ref_mem[o.addr] = o.wdata;
      else if (w) m_r1 = ref_mem[o.addr];
      else        m_r0 = ref_mem[o.addr];
      m_last = w;
      e.port = w; e.we = o.we; e.addr = o.addr; e.wdata = o.wdata;
      e.r0 = m_r0; e.r1 = m_r1; e.cyc = 32'(t);
      exp_q.push_back(e);
      t += 3;
    end
    if (ops0.size() > 0) begin drive0(ops0[0]); p0_req = 1'b1; end
    if (ops1.size() > 0) begin drive1(ops1[0]); p1_req = 1'b1; end
    i0 = 0; i1 = 0;
    budget = 3 * (ops0.size() + ops1.size()) + 8;
    while ((i0 < ops0.size() || i1 < ops1.size()) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (early && cyc == n + 1) begin p0_req = 1'b0; p1_req = 1'b0; end
      if (p0_ack) begin
        i0++;
        if (i0 < ops0.size()) drive0(ops0[i0]); else p0_req = 1'b0;
      end
      if (p1_ack) begin
        i1++;
        if (i1 < ops1.size()) drive1(ops1[i1]); else p1_req = 1'b0;
      end
    end
    if (i0 < ops0.size() || i1 < ops1.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL round_timeout: acks got p0=%0d p1=%0d required p0=%0d p1=%0d",
               i0, i1, ops0.size(), ops1.size());
      exp_q.delete();
      p0_req = 1'b0; p1_req = 1'b0;
      repeat (4) @(negedge clk);
    end
    ops0.delete();
    ops1.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int   nce_run;
    exp_t e;
    nce_run = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        nce_run = 0;
      end else begin
        if (!ram_nce) begin
          nce_run++;
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL spurious_access: got ram_nce=0 addr=%h required ram_nce=1", ram_addr);
          end else begin
            e = exp_q[0];
            check("ram_addr", 32'(ram_addr), 32'(e.addr));
            check("ram_we", 32'(ram_we), 32'(e.we));
            check("ram_re", 32'(ram_re), 32'(!e.we));
            if (e.we) check("ram_wdata", ram_wdata, e.wdata);
          end
        end else if (nce_run != 0) begin
          check("nce_low_cycles", 32'(nce_run), 32'd1);
          nce_run = 0;
        end
        if (p0_ack || p1_ack) begin
          check("single_ack", 32'(p0_ack & p1_ack), 32'd0);
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL extra_ack: got p0_ack=%0b p1_ack=%0b required none", p0_ack, p1_ack);
          end else begin
            e = exp_q.pop_front();
            check("ack_port", 32'(p1_ack), 32'(e.port));
            check("ack_cycle", 32'(cyc), e.cyc);
            check("p0_rdata", p0_rdata, e.r0);
            check("p1_rdata", p1_rdata, e.r1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    nrst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    m_r0 = 0; m_r1 = 0; m_last = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    nrst = 1'b1;

    // Contention straight after reset: port 0 first, port 1 three cycles later.
    ops0.push_back(mk_op(1'b0, 8'h01, 32'h0));
    ops1.push_back(mk_op(1'b0, 8'h02, 32'h0));
    run_round(1'b0);

    ops0.push_back(mk_op(1'b1, 8'h10, 32'hDEADBEEF));
    run_round(1'b0);
    ops0.push_back(mk_op(1'b0, 8'h10, 32'h0));
    run_round(1'b0);

    ops1.push_back(mk_op(1'b1, 8'hFF, 32'h12345678));
    run_round(1'b0);
    ops0.push_back(mk_op(1'b0, 8'hFF, 32'h0));
    run_round(1'b0);

    // Both ports hold req for three transactions each.
    for (int k = 0; k < 3; k++) begin
      ops0.push_back(rand_op());
      ops1.push_back(rand_op());
    end
    run_round(1'b0);

    // Reset asserted in the ACCESS cycle of a port 1 write, before the write negedge.
    @(negedge clk);
    drive1(mk_op(1'b1, 8'($urandom_range(0, 15)), $urandom));
    p1_req = 1'b1;
    @(posedge clk);
    #2;
    nrst = 1'b0;
    p1_req = 1'b0;
    #1;
    check_reset_values("midreset");
    m_r0 = 0; m_r1 = 0; m_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midreset_no_p1_ack", 32'(p1_ack), 32'd0);
    end
    nrst = 1'b1;

    ops0.push_back(mk_op(1'b0, 8'h00, 32'h0));
    run_round(1'b0);

    ops0.push_back(mk_op(1'b0, 8'h10, 32'h0));
    run_round(1'b1);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: ops0.push_back(rand_op());
        1: ops1.push_back(rand_op());
        2: begin
          for (int k = 0; k < $urandom_range(1, 3); k++) ops0.push_back(rand_op());
          for (int k = 0; k < $urandom_range(1, 3); k++) ops1.push_back(rand_op());
        end
        default: begin
          if ($urandom_range(0, 1) == 0) ops0.push_back(rand_op());
          else                           ops1.push_back(rand_op());
        end
      endcase
      run_round(ops0.size() + ops1.size() == 1 && $urandom_range(0, 1) == 1);
    end

    repeat (6) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
